// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared FSM state type and width helpers for the cross-correlation engine
package xcorr_pkg;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  function automatic int aw_f(input int n);
    return $clog2(n);
  endfunction
  function automatic int lw_f(input int n);
    return $clog2(2 * n - 1);
  endfunction
  function automatic int rw_f(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction
endpackage

// File: rtl/xcorr_mac.sv
// xcorr_mac: signed multiply-accumulate at full result width, no saturation
module xcorr_mac #(
  parameter int DW = 10,
  parameter int RW = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [RW-1:0] acc
);
  // clear wins over accumulate; operands widened before multiply
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + RW'(a) * RW'(b);
endmodule

// File: rtl/xcorr_engine.sv
// xcorr_engine: lag-serial cross-correlation r[m] of two N-sample buffers; XCORR_PEAK_EN adds peak_lag/peak_val
module xcorr_engine
  import xcorr_pkg::*;
#(
  parameter int N = 16,
  parameter int DW = 10,
  localparam int AW = aw_f(N),
  localparam int LW = lw_f(N),
  localparam int RW = rw_f(DW, N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic                 wr_sel,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LW-1:0]        out_lag,
  output logic signed [RW-1:0] out_data,
  output logic                 done
`ifdef XCORR_PEAK_EN
  ,
  output logic [LW-1:0]        peak_lag,
  output logic signed [RW-1:0] peak_val
`endif
);
  state_t state, nxt;
  logic [AW:0] cnt;
  logic [LW-1:0] lag;
  logic signed [DW-1:0] bufa [N];
  logic signed [DW-1:0] bufb [N];
  logic signed [DW-1:0] a_s, b_s;
  logic accept, last;
  int bi;
  assign busy = state != IDLE;
  assign out_valid = state == OUT;
  assign out_lag = lag;
  assign accept = state == OUT && out_ready && !abort;
  assign last = lag == LW'(2 * N - 2);
  // sample buffers: no reset, writes only while idle
  always_ff @(posedge clk)
    if (wr_en && !busy && int'(wr_addr) < N) begin
      if (wr_sel) bufb[wr_addr] <= wr_data;
      else bufa[wr_addr] <= wr_data;
    end
  // operand fetch: MAC cycle cnt handles term j=cnt-1, B index out of range contributes zero
  always_comb begin
    bi = int'(cnt) + N - 2 - int'(lag);
    a_s = bufa[AW'(cnt - 1'b1)];
    b_s = (bi >= 0 && bi < N) ? bufb[AW'(bi)] : '0;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // next state: first MAC cycle clears, then N accumulate cycles; abort beats acceptance
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? MAC : IDLE;
      MAC:     nxt = abort ? IDLE : (cnt == (AW+1)'(N)) ? OUT : MAC;
      OUT:     nxt = abort ? IDLE : accept ? (last ? IDLE : MAC) : OUT;
      default: nxt = IDLE;
    endcase
  end
  // cycle counter within MAC, current lag and end-of-run pulse
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      lag <= '0;
      done <= 1'b0;
    end else begin
      cnt <= (state == MAC) ? cnt + 1'b1 : '0;
      lag <= (state == IDLE && start) ? '0 : (accept && !last) ? lag + 1'b1 : lag;
      done <= accept && last;
    end
  xcorr_mac #(.DW(DW), .RW(RW)) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == MAC && cnt == '0),
    .en   (state == MAC && cnt != '0),
    .a    (a_s),
    .b    (b_s),
    .acc  (out_data)
  );
`ifdef XCORR_PEAK_EN
  // running maximum over accepted lags; lag 0 seeds it, strict compare keeps the lowest lag on ties
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      peak_lag <= '0;
      peak_val <= '0;
    end else if (accept && (lag == '0 || out_data > peak_val)) begin
      peak_lag <= lag;
      peak_val <= out_data;
    end
`endif
endmodule

// File: tb/tb_xcorr_engine.sv
// tb_xcorr_engine: randomized self-checking bench for xcorr_engine against an arithmetic reference
module tb_xcorr_engine;
  localparam int N = 4, DW = 10, AW = 2, LW = 3, RW = 22;
  logic clk = 0, rst_n = 1, wr_en = 0, wr_sel = 0, start = 0, abort = 0, out_ready = 1;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic busy, out_valid, done;
  logic [LW-1:0] out_lag;
  logic [RW-1:0] out_data;
`ifdef XCORR_PEAK_EN
  logic [LW-1:0] peak_lag;
  logic [RW-1:0] peak_val;
`endif
  int ma[N], mb[N];
  int checks = 0, passed = 0;

  xcorr_engine #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .abort(abort), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_lag(out_lag), .out_data(out_data), .done(done)
`ifdef XCORR_PEAK_EN
    , .peak_lag(peak_lag), .peak_val(peak_val)
`endif
  );

  always #5 clk = ~clk;

  function automatic longint model_r(input int m);
    longint s = 0;
    for (int j = 0; j < N; j++) begin
      int k = j + N - 1 - m;
      if (k >= 0 && k < N) s += longint'(ma[j]) * longint'(mb[k]);
    end
    return s;
  endfunction

  task automatic write_bufs();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < N; i++) begin
        wr_en = 1; wr_sel = s[0]; wr_addr = AW'(i); wr_data = DW'(s == 1 ? mb[i] : ma[i]);
        @(negedge clk);
      end
    wr_en = 0;
  endtask

  task automatic rand_bufs();
    for (int i = 0; i < N; i++) begin
      ma[i] = int'($urandom_range(0, 1023)) - 512;
      mb[i] = int'($urandom_range(0, 1023)) - 512;
    end
  endtask

  task automatic run_and_check(input string tag, input int bp_lag, input int bp_len, input bit hostile);
    longint exp;
    int lat;
`ifdef XCORR_PEAK_EN
    int pk_lag = 0;
    longint pk_val = 0;
`endif
    out_ready = 1; start = 1;
    @(negedge clk);
    start = 0;
    for (int m = 0; m < 2 * N - 1; m++) begin
      lat = 0;
      while (!out_valid && lat <= 3 * N) begin
        if (hostile) begin
          start = 1; wr_en = 1; wr_sel = 1'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
        end
        @(negedge clk);
        lat++; start = 0; wr_en = 0;
      end
      exp = model_r(m);
      checks++;
      if (lat !== N + 1) $display("FAIL %s latency lag %0d: got %0d cycles, want %0d", tag, m, lat, N + 1);
      else passed++;
      if (!out_valid) return;
      checks++;
      if (out_lag !== LW'(m)) $display("FAIL %s out_lag: got %0d, want %0d", tag, out_lag, m);
      else passed++;
      checks++;
      if ($signed(out_data) !== exp) $display("FAIL %s out_data lag %0d: got %0d, want %0d", tag, m, $signed(out_data), exp);
      else passed++;
`ifdef XCORR_PEAK_EN
      if (m == 0 || exp > pk_val) begin pk_lag = m; pk_val = exp; end
`endif
      if (m == bp_lag) begin
        out_ready = 0;
        repeat (bp_len) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_lag !== LW'(m) || $signed(out_data) !== exp)
            $display("FAIL %s hold lag %0d: valid %0b lag %0d data %0d, want 1 %0d %0d", tag, m, out_valid, out_lag, $signed(out_data), m, exp);
          else passed++;
        end
        out_ready = 1;
      end
      @(negedge clk);
      if (m < 2 * N - 2) begin
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) $display("FAIL %s mid-run lag %0d: done %0b busy %0b, want 0 1", tag, m, done, busy);
        else passed++;
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL %s done: done %0b busy %0b valid %0b, want 1 0 0", tag, done, busy, out_valid);
    else passed++;
`ifdef XCORR_PEAK_EN
    checks++;
    if (peak_lag !== LW'(pk_lag) || $signed(peak_val) !== pk_val)
      $display("FAIL %s peak: lag %0d val %0d, want %0d %0d", tag, peak_lag, $signed(peak_val), pk_lag, pk_val);
    else passed++;
`endif
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL %s done width: done still %0b, want 0", tag, done);
    else passed++;
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, out_valid, done} !== 3'b000 || out_lag !== '0 || out_data !== '0)
      $display("FAIL reset: busy %0b valid %0b done %0b lag %0d data %0d, want all 0", busy, out_valid, done, out_lag, out_data);
    else passed++;
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_impulse();
    ma = '{1, 2, 3, 4}; mb = '{1, 0, 0, 0};
    write_bufs();
    run_and_check("impulse", -1, 0, 0);
  endtask

  task automatic test_extreme();
    ma = '{-512, -512, -512, -512}; mb = '{-512, -512, -512, -512};
    write_bufs();
    run_and_check("extreme", -1, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      rand_bufs();
      write_bufs();
      run_and_check("random", -1, 0, r[0]);
    end
  endtask

  task automatic test_back_to_back();
    rand_bufs();
    write_bufs();
    run_and_check("b2b_first", -1, 0, 1);
    run_and_check("b2b_second", -1, 0, 0);
  endtask

  task automatic test_backpressure();
    rand_bufs();
    mb[0] = 77;
    write_bufs();
    run_and_check("backpressure", 2, 5, 0);
  endtask

  task automatic test_abort();
    ma = '{1, 2, 3, 4}; mb = '{1, 0, 0, 0};
    write_bufs();
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL abort: busy %0b valid %0b, want 0 0", busy, out_valid);
    else passed++;
    repeat (2 * N + 4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0)
        $display("FAIL abort quiet: valid %0b done %0b busy %0b, want 0 0 0", out_valid, done, busy);
      else passed++;
    end
    abort = 1;
    @(negedge clk);
    abort = 0;
    run_and_check("abort_rerun", -1, 0, 0);
  endtask

  task automatic test_reset_mid();
    int t = 0;
    rand_bufs();
    ma[0] = 300; mb[N-1] = 200;
    write_bufs();
    out_ready = 1; start = 1;
    @(negedge clk);
    start = 0;
    while (!(out_valid && out_lag == LW'(2)) && t < 100) begin
      @(negedge clk);
      t++;
    end
    out_ready = 0;
    checks++;
    if (t >= 100) $display("FAIL reset_mid setup: lag 2 never offered, got lag %0d", out_lag);
    else passed++;
    #2 rst_n = 0;
    #1;
    checks++;
    if ({busy, out_valid, done} !== 3'b000 || out_lag !== '0 || out_data !== '0)
      $display("FAIL reset_mid: busy %0b valid %0b done %0b lag %0d data %0d, want all 0", busy, out_valid, done, out_lag, out_data);
    else passed++;
    @(negedge clk);
    rst_n = 1; out_ready = 1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL reset_mid idle: busy %0b valid %0b, want 0 0", busy, out_valid);
      else passed++;
    end
    write_bufs();
    run_and_check("reset_rerun", -1, 0, 0);
  endtask

`ifdef XCORR_PEAK_EN
  task automatic test_peak();
    ma = '{1, 2, 3, 4}; mb = '{1, 0, 0, 0};
    write_bufs();
    run_and_check("peak_impulse", -1, 0, 0);
    checks++;
    if (peak_lag !== LW'(6) || $signed(peak_val) !== 4) $display("FAIL peak impulse: lag %0d val %0d, want 6 4", peak_lag, $signed(peak_val));
    else passed++;
    ma = '{1, 1, 1, 1}; mb = '{1, 1, 1, 1};
    write_bufs();
    run_and_check("peak_ones", -1, 0, 0);
    checks++;
    if (peak_lag !== LW'(3) || $signed(peak_val) !== 4) $display("FAIL peak ones: lag %0d val %0d, want 3 4", peak_lag, $signed(peak_val));
    else passed++;
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_impulse();
    test_extreme();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_abort();
    test_reset_mid();
`ifdef XCORR_PEAK_EN
    test_peak();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/xcorr_engine.md
XCORR_ENGINE -- requirements
Module: xcorr_engine

Interface
REQ-001 SHALL have parameter N, default 16: samples per input sequence, N >= 2.
REQ-002 SHALL have parameter DW, default 10: sample width, signed two's complement.
REQ-003 SHALL derive localparams AW = clog2(N), LW = clog2(2N-1), RW = 2*DW + AW.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk, input, 1: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port wr_en, input, 1: sample write strobe.
REQ-008 SHALL have port wr_sel, input, 1: buffer select (0 = A, 1 = B).
REQ-009 SHALL have port wr_addr, input, AW: sample index.
REQ-010 SHALL have port wr_data, input, DW: sample value.
REQ-011 SHALL have port start, input, 1: begin correlation.
REQ-012 SHALL have port abort, input, 1: synchronous cancel.
REQ-013 SHALL have port busy, output, 1: computation in progress.
REQ-014 SHALL have port out_valid, output, 1: result word available.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the result word.
REQ-016 SHALL have port out_lag, output, LW: lag index m of out_data.
REQ-017 SHALL have port out_data, output, RW: signed r[m].
REQ-018 SHALL have port done, output, 1: one-cycle pulse after the last lag is accepted.

Function
REQ-019 SHALL compute r[m] = sum over j=0..N-1 of A[j]*B[j+N-1-m], m = 0..2N-2; terms with an out-of-range B index SHALL contribute 0.
REQ-020 SHALL use states IDLE, MAC, OUT.
- IDLE->MAC on start.
- MAC->OUT after exactly N accumulate cycles.
- OUT->MAC on out_valid&&out_ready when m < 2N-2.
- OUT->IDLE on acceptance of lag 2N-2.
REQ-021 SHALL clear the accumulator on entry to MAC and add one signed product per MAC cycle at full RW width without saturation.
REQ-022 SHALL assert out_valid first N+1 cycles after start is sampled in IDLE; each subsequent lag SHALL follow N+1 cycles after acceptance of the previous lag.
REQ-023 SHALL hold out_valid, out_lag and out_data stable while out_valid && !out_ready.
REQ-024 SHALL drive busy high in MAC and OUT, and low in IDLE.
REQ-025 SHALL pulse done for exactly one cycle, in the cycle after acceptance of lag 2N-2.
REQ-026 SHALL ignore wr_en and start while busy; buffers SHALL persist across runs.
REQ-027 SHALL, on abort in MAC or OUT, enter IDLE next cycle with out_valid low, no done pulse, and buffers kept; abort in IDLE has no effect.
REQ-028 SHALL give abort priority over out_ready when both are asserted in the same cycle: the word is not counted as accepted.

Reset
REQ-029 SHALL, while rst_n is low, immediately force IDLE, busy=0, out_valid=0, done=0, out_lag=0, out_data=0 and the accumulator to 0; buffer contents are undefined after reset.
REQ-030 SHALL treat reset mid-operation as abort plus output clear; operation resumes only on a new start.

Configuration
REQ-031 SHALL honour macro XCORR_PEAK_EN. When defined, it adds outputs peak_lag (LW) and peak_val (RW).
- They track the maximum signed r[m] of the run, using strict greater-than, so the lowest lag wins ties.
- They update as each lag is accepted and are valid from the done pulse.
- They are held until the next start, and are 0 after reset.
When undefined, these ports and their logic are absent.

Structure
REQ-032 SHALL place the state enum (IDLE/MAC/OUT) and the width helper functions for AW, LW and RW in shared package xcorr_pkg.
REQ-033 SHALL implement the signed multiply-accumulate datapath as sub-module xcorr_mac: ports clk, rst_n, clr, en, a, b, acc.

Verification (N=4, DW=10)
REQ-034 SHALL cover impulse: A=[1,2,3,4], B=[1,0,0,0], start, out_ready=1 -> out_data 0,0,0,1,2,3,4 for lags 0..6, then done; first out_valid 5 cycles after start.
REQ-035 SHALL cover signed extreme: A and B all -512 -> r[3]=1048576, r[0]=r[6]=262144, with no overflow in 22 bits.
REQ-036 SHALL cover backpressure: out_ready low for 5 cycles at lag 2 -> out_lag=2 and out_data stable throughout, with no extra lags emitted.
REQ-037 SHALL cover abort: abort asserted in the 2nd MAC cycle -> busy=0 next cycle, no out_valid and no done; a rerun with the same buffers reproduces REQ-034.
REQ-038 SHALL cover reset and ignore rules: rst_n low during OUT -> all outputs 0 immediately; start and wr_en during busy -> no effect on results.
REQ-039 SHALL cover peak (XCORR_PEAK_EN): stimulus of REQ-034 -> peak_lag=6, peak_val=4 at done; with A=B=[1,1,1,1] -> peak_lag=3, peak_val=4.
